alu_req_arbiter: RTL and testbench

- Shares the single clocked ALU between N_REQ requesters (for example, testbench agents or upstream pipeline stages).
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- A round-robin arbiter grants one request at a time and drives the ALU operand/opcode inputs.
- An FSM waits out the ALU latency, captures result and flags, and routes them back to the granted requester.
- Sits between the requesters and the ALU's a_i/b_i/op_i/result_o/zero_o/carry_o/error_o pins.

---
 rtl/alu_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one clocked ALU between N_REQ requesters.
// Each operation is issued, waited out for ALU_LAT cycles, then returned to its requester.
module alu_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*DATA_W-1:0]   req_a_i,
  input  logic [N_REQ*DATA_W-1:0]   req_b_i,
  input  logic [N_REQ*OP_W-1:0]     req_op_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  input  logic [N_REQ-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_zero_o,
  output logic                      rsp_carry_o,
  output logic                      rsp_error_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  output logic [OP_W-1:0]           alu_op_o,
  input  logic [DATA_W-1:0]         alu_result_i,
  input  logic                      alu_zero_i,
  input  logic                      alu_carry_i,
  input  logic                      alu_error_i,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  grant_id_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_q;
  logic [DATA_W-1:0]  alu_a_q, alu_b_q;
  logic [OP_W-1:0]    alu_op_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic               rsp_zero_q, rsp_carry_q, rsp_error_q;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [OP_W-1:0]    sel_op;
  logic               handshake;
  logic               capture;

  // Rotating priority search: first valid request at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid_i[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        sel_a  = req_a_i[k*DATA_W +: DATA_W];
        sel_b  = req_b_i[k*DATA_W +: DATA_W];
        sel_op = req_op_i[k*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    int nxt;
    nxt = int'(winner) + 1;
    if (nxt >= N_REQ) nxt = 0;
    rr_ptr_d = ID_W'(nxt);
  end

  assign handshake = (state_q == IDLE) && found;
  assign capture   = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands are taken only on the grant edge, so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= winner;
      alu_a_q  <= sel_a;
      alu_b_q  <= sel_b;
      alu_op_q <= sel_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
    end else if (capture) begin
      rsp_result_q <= alu_result_i;
      rsp_zero_q   <= alu_zero_i;
      rsp_carry_q  <= alu_carry_i;
      rsp_error_q  <= alu_error_i;
    end
  end

  // Ready is gated by reset too, so nothing is offered while rst_n is held low.
  assign req_ready_o  = (handshake && rst_n) ? (N_REQ'(1) << winner) : '0;
  assign rsp_valid_o  = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_error_o  = rsp_error_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign busy_o       = (state_q != IDLE);
  assign grant_id_o   = grant_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one instance with a 1-stage ALU model,
// a second with a 3-stage ALU model for the latency case.
module tb_alu_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstN;

  logic [N-1:0]    reqValidA, reqReadyA, rspValidA, rspReadyA;
  logic [N*DW-1:0] reqAA, reqBA;
  logic [N*OW-1:0] reqOpA;
  logic [DW-1:0]   rspResultA, aluAA, aluBA, aluResA;
  logic            rspZeroA, rspCarryA, rspErrorA, aluZeroA, aluCarryA, aluErrA, busyA;
  logic [OW-1:0]   aluOpA;
  logic [1:0]      grantA;

  logic [N-1:0]    reqValidB, reqReadyB, rspValidB, rspReadyB;
  logic [N*DW-1:0] reqAB, reqBB;
  logic [N*OW-1:0] reqOpB;
  logic [DW-1:0]   rspResultB, aluAB, aluBB, aluResB;
  logic            rspZeroB, rspCarryB, rspErrorB, aluZeroB, aluCarryB, aluErrB, busyB;
  logic [OW-1:0]   aluOpB;
  logic [1:0]      grantB;

  int checks = 0;
  int errors = 0;

  alu_req_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(1)) dutA (
    .clk(clock), .rst_n(rstN),
    .req_valid_i(reqValidA), .req_ready_o(reqReadyA),
    .req_a_i(reqAA), .req_b_i(reqBA), .req_op_i(reqOpA),
    .rsp_valid_o(rspValidA), .rsp_ready_i(rspReadyA),
    .rsp_result_o(rspResultA), .rsp_zero_o(rspZeroA), .rsp_carry_o(rspCarryA), .rsp_error_o(rspErrorA),
    .alu_a_o(aluAA), .alu_b_o(aluBA), .alu_op_o(aluOpA),
    .alu_result_i(aluResA), .alu_zero_i(aluZeroA), .alu_carry_i(aluCarryA), .alu_error_i(aluErrA),
    .busy_o(busyA), .grant_id_o(grantA)
  );

  alu_req_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(3)) dutB (
    .clk(clock), .rst_n(rstN),
    .req_valid_i(reqValidB), .req_ready_o(reqReadyB),
    .req_a_i(reqAB), .req_b_i(reqBB), .req_op_i(reqOpB),
    .rsp_valid_o(rspValidB), .rsp_ready_i(rspReadyB),
    .rsp_result_o(rspResultB), .rsp_zero_o(rspZeroB), .rsp_carry_o(rspCarryB), .rsp_error_o(rspErrorB),
    .alu_a_o(aluAB), .alu_b_o(aluBB), .alu_op_o(aluOpB),
    .alu_result_i(aluResB), .alu_zero_i(aluZeroB), .alu_carry_i(aluCarryB), .alu_error_i(aluErrB),
    .busy_o(busyB), .grant_id_o(grantB)
  );

  // ALU model: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, others flag an error.
  function automatic logic [10:0] aluFn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] wide;
    logic       err;
    wide = '0;
    err  = 1'b0;
    case (op)
      3'd0: wide = {1'b0, a} + {1'b0, b};
      3'd1: wide = {1'b0, a} - {1'b0, b};
      3'd2: wide = {1'b0, a & b};
      3'd3: wide = {1'b0, a | b};
      3'd4: wide = {1'b0, a ^ b};
      default: err = 1'b1;
    endcase
    return {err, wide[8], (wide[7:0] == 8'h00), wide[7:0]};
  endfunction

  logic [10:0] stageA;
  logic [10:0] stageB [3];

  // One register stage for dutA, three for dutB.
  always_ff @(posedge clock) begin
    stageA    <= aluFn(aluAA, aluBA, aluOpA);
    stageB[0] <= aluFn(aluAB, aluBB, aluOpB);
    stageB[1] <= stageB[0];
    stageB[2] <= stageB[1];
  end

  assign {aluErrA, aluCarryA, aluZeroA, aluResA} = stageA;
  assign {aluErrB, aluCarryB, aluZeroB, aluResB} = stageB[2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    reqAA[k*DW +: DW] = a;
    reqBA[k*DW +: DW] = b;
    reqOpA[k*OW +: OW] = op;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstN = 1'b0;
    reqValidA = '0; rspReadyA = '0; reqAA = '0; reqBA = '0; reqOpA = '0;
    reqValidB = '0; rspReadyB = '0; reqAB = '0; reqBB = '0; reqOpB = '0;

    repeat (2) tick();
    checkOutput("rst_busy", 32'(busyA), 32'h0);
    checkOutput("rst_grant", 32'(grantA), 32'h0);
    checkOutput("rst_ready", 32'(reqReadyA), 32'h0);
    checkOutput("rst_rspvalid", 32'(rspValidA), 32'h0);
    checkOutput("rst_alu_a", 32'(aluAA), 32'h0);
    checkOutput("rst_result", 32'(rspResultA), 32'h0);
    rstN = 1'b1;
    tick();

    $display("[TB] single request");
    applyStimulus(0, 8'hF0, 8'h20, 3'd0);
    reqValidA = 4'b0001;
    #1;
    checkOutput("single_ready", 32'(reqReadyA), 32'h1);
    checkOutput("single_idle_busy", 32'(busyA), 32'h0);
    tick();
    reqValidA = '0;
    checkOutput("single_issue_busy", 32'(busyA), 32'h1);
    checkOutput("single_grant", 32'(grantA), 32'h0);
    checkOutput("single_alu_a", 32'(aluAA), 32'hF0);
    checkOutput("single_alu_b", 32'(aluBA), 32'h20);
    checkOutput("single_alu_op", 32'(aluOpA), 32'h0);
    checkOutput("single_issue_rspvalid", 32'(rspValidA), 32'h0);
    tick();
    checkOutput("single_wait_rspvalid", 32'(rspValidA), 32'h0);
    tick();
    checkOutput("single_rspvalid", 32'(rspValidA), 32'h1);
    checkOutput("single_result", 32'(rspResultA), 32'h10);
    checkOutput("single_carry", 32'(rspCarryA), 32'h1);
    checkOutput("single_zero", 32'(rspZeroA), 32'h0);
    checkOutput("single_error", 32'(rspErrorA), 32'h0);
    rspReadyA = 4'b0001;
    tick();
    checkOutput("single_done_busy", 32'(busyA), 32'h0);
    checkOutput("single_done_rspvalid", 32'(rspValidA), 32'h0);
    rspReadyA = '0;

    $display("[TB] round robin");
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    for (int k = 0; k < N; k++) applyStimulus(k, 8'(k + 1), 8'h01, 3'd0);
    reqValidA = 4'hF;
    rspReadyA = 4'hF;
    for (int n = 0; n < 6; n++) begin
      #1;
      checkOutput($sformatf("rr_ready_%0d", n), 32'(reqReadyA), 32'(1 << (n % 4)));
      tick();
      checkOutput($sformatf("rr_grant_%0d", n), 32'(grantA), 32'(n % 4));
      tick();
      tick();
      checkOutput($sformatf("rr_rspvalid_%0d", n), 32'(rspValidA), 32'(1 << (n % 4)));
      checkOutput($sformatf("rr_result_%0d", n), 32'(rspResultA), 32'((n % 4) + 2));
      tick();
    end

    $display("[TB] response backpressure");
    rspReadyA = 4'b1011;
    #1;
    checkOutput("bp_ready", 32'(reqReadyA), 32'h4);
    tick();
    tick();
    tick();
    checkOutput("bp_rspvalid", 32'(rspValidA), 32'h4);
    checkOutput("bp_result", 32'(rspResultA), 32'h4);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(rspValidA), 32'h4);
      checkOutput($sformatf("bp_hold_result_%0d", i), 32'(rspResultA), 32'h4);
      checkOutput($sformatf("bp_hold_busy_%0d", i), 32'(busyA), 32'h1);
      checkOutput($sformatf("bp_hold_ready_%0d", i), 32'(reqReadyA), 32'h0);
    end
    rspReadyA = 4'hF;
    reqValidA = '0;
    tick();
    checkOutput("bp_release_busy", 32'(busyA), 32'h0);
    checkOutput("bp_release_rspvalid", 32'(rspValidA), 32'h0);
    tick();
    checkOutput("bp_idle_busy", 32'(busyA), 32'h0);
    checkOutput("bp_idle_ready", 32'(reqReadyA), 32'h0);

    $display("[TB] zero and error flags");
    applyStimulus(1, 8'h05, 8'h05, 3'd1);
    reqValidA = 4'b0010;
    #1;
    checkOutput("zero_ready", 32'(reqReadyA), 32'h2);
    tick();
    reqValidA = '0;
    tick();
    tick();
    checkOutput("zero_rspvalid", 32'(rspValidA), 32'h2);
    checkOutput("zero_result", 32'(rspResultA), 32'h0);
    checkOutput("zero_flag", 32'(rspZeroA), 32'h1);
    checkOutput("zero_carry", 32'(rspCarryA), 32'h0);
    checkOutput("zero_error", 32'(rspErrorA), 32'h0);
    tick();
    applyStimulus(3, 8'h09, 8'h03, 3'd7);
    reqValidA = 4'b1000;
    #1;
    checkOutput("err_ready", 32'(reqReadyA), 32'h8);
    tick();
    reqValidA = '0;
    applyStimulus(3, 8'hAA, 8'hBB, 3'd0);
    checkOutput("err_alu_a_held", 32'(aluAA), 32'h09);
    checkOutput("err_alu_op_held", 32'(aluOpA), 32'h7);
    tick();
    tick();
    checkOutput("err_rspvalid", 32'(rspValidA), 32'h8);
    checkOutput("err_flag", 32'(rspErrorA), 32'h1);
    checkOutput("err_result", 32'(rspResultA), 32'h0);
    tick();

    $display("[TB] async reset during wait");
    applyStimulus(2, 8'h01, 8'h01, 3'd0);
    reqValidA = 4'b0100;
    tick();
    tick();
    checkOutput("ar_wait_busy", 32'(busyA), 32'h1);
    reqValidA = 4'hF;
    rstN = 1'b0;
    #1;
    checkOutput("ar_busy", 32'(busyA), 32'h0);
    checkOutput("ar_alu_a", 32'(aluAA), 32'h0);
    checkOutput("ar_grant", 32'(grantA), 32'h0);
    checkOutput("ar_ready", 32'(reqReadyA), 32'h0);
    checkOutput("ar_error", 32'(rspErrorA), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("ar_no_rsp_%0d", i), 32'(rspValidA), 32'h0);
    end
    rstN = 1'b1;
    #1;
    checkOutput("ar_next_grant", 32'(reqReadyA), 32'h1);
    reqValidA = '0;
    tick();
    checkOutput("ar_idle_busy", 32'(busyA), 32'h0);

    $display("[TB] three-cycle ALU latency");
    reqAB[7:0] = 8'hF0;
    reqBB[7:0] = 8'h20;
    reqOpB[2:0] = 3'd0;
    reqValidB = 4'b0001;
    rspReadyB = 4'hF;
    #1;
    checkOutput("lat3_ready", 32'(reqReadyB), 32'h1);
    tick();
    reqValidB = '0;
    reqAB = '0;
    reqBB = '0;
    checkOutput("lat3_issue_a", 32'(aluAB), 32'hF0);
    checkOutput("lat3_issue_b", 32'(aluBB), 32'h20);
    checkOutput("lat3_issue_op", 32'(aluOpB), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("lat3_wait_a_%0d", i), 32'(aluAB), 32'hF0);
      checkOutput($sformatf("lat3_wait_b_%0d", i), 32'(aluBB), 32'h20);
      checkOutput($sformatf("lat3_wait_op_%0d", i), 32'(aluOpB), 32'h0);
      checkOutput($sformatf("lat3_wait_rspvalid_%0d", i), 32'(rspValidB), 32'h0);
      checkOutput($sformatf("lat3_wait_busy_%0d", i), 32'(busyB), 32'h1);
    end
    tick();
    checkOutput("lat3_rspvalid", 32'(rspValidB), 32'h1);
    checkOutput("lat3_result", 32'(rspResultB), 32'h10);
    checkOutput("lat3_carry", 32'(rspCarryB), 32'h1);
    tick();
    checkOutput("lat3_done_busy", 32'(busyB), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
